noc_rsc_ni: RTL and testbench

//  Resource network interface for one mesh_xy NoC node; sits between a local resource and its switch port 0.
//  TX: accepts payload + destination coordinates over valid/ready, buffers them, and issues packets

---
 rtl/noc_rsc_ni.sv | 127 ++++++++++++
 tb/tb_noc_rsc_ni.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/noc_rsc_ni.sv
// noc_rsc_ni: resource network interface between a local resource and mesh switch port 0.
// TX FIFO feeds the switch with registered wren/pckt; RX FIFO buffers switch traffic for the resource.
module noc_rsc_ni #(
    parameter int X_CORD       = 0,
    parameter int Y_CORD       = 0,
    parameter int PCKT_XADDR_W = 2,
    parameter int PCKT_YADDR_W = 2,
    parameter int PCKT_DATA_W  = 8,
    parameter int FIFO_DEPTH_W = 3,
    parameter int CNT_W        = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic [PCKT_DATA_W-1:0]                       tx_data_i,
    input  logic [PCKT_XADDR_W-1:0]                      tx_xaddr_i,
    input  logic [PCKT_YADDR_W-1:0]                      tx_yaddr_i,
    input  logic                                         tx_valid_i,
    output logic                                         tx_ready_o,
    output logic [PCKT_XADDR_W+PCKT_YADDR_W+PCKT_DATA_W-1:0] pckt_o,
    output logic                                         wren_o,
    input  logic                                         full_i,
    input  logic                                         ovrflw_i,
    input  logic [PCKT_XADDR_W+PCKT_YADDR_W+PCKT_DATA_W-1:0] pckt_i,
    input  logic                                         wren_i,
    output logic                                         full_o,
    output logic                                         ovrflw_o,
    output logic [PCKT_DATA_W-1:0]                       rx_data_o,
    output logic                                         rx_misrt_o,
    output logic                                         rx_valid_o,
    input  logic                                         rx_ready_i,
    output logic                                         tx_err_o,
    output logic [CNT_W-1:0]                             tx_cnt_o,
    output logic [CNT_W-1:0]                             rx_cnt_o,
    output logic [7:0]                                   drop_cnt_o
);
    localparam int P  = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W;
    localparam int AW = FIFO_DEPTH_W;
    localparam int D  = 2 ** FIFO_DEPTH_W;
    localparam logic [AW:0] DEPTH = (AW+1)'(D);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    logic [P-1:0]           tx_mem_q [D];
    logic [PCKT_DATA_W:0]   rx_mem_q [D];
    logic [AW:0]            tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW:0]            rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [AW:0]            tx_lvl, rx_lvl;
    logic                   tx_full, tx_push, tx_pop;
    logic                   rx_full, rx_push, rx_pop, rx_drop, misrt;
    logic [PCKT_DATA_W:0]   rx_head;
    logic                   wren_q, wren_d, ovrflw_q, ovrflw_d, tx_err_q, tx_err_d;
    logic [P-1:0]           pckt_q, pckt_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;

    always_comb begin
        tx_lvl     = tx_wp_q - tx_rp_q;
        tx_full    = tx_lvl == DEPTH;
        tx_push    = tx_valid_i & ~tx_full;
        tx_pop     = (tx_wp_q != tx_rp_q) & ~full_i;
        tx_wp_d    = tx_push ? tx_wp_q + ONE : tx_wp_q;
        tx_rp_d    = tx_pop ? tx_rp_q + ONE : tx_rp_q;
        wren_d     = tx_pop;
        pckt_d     = tx_pop ? tx_mem_q[tx_rp_q[AW-1:0]] : pckt_q;
        tx_err_d   = tx_err_q | ovrflw_i;
        tx_cnt_d   = tx_cnt_q + CNT_W'(wren_q);
        rx_lvl     = rx_wp_q - rx_rp_q;
        rx_full    = rx_lvl == DEPTH;
        rx_head    = rx_mem_q[rx_rp_q[AW-1:0]];
        // Full is judged on pre-edge state, so a same-cycle pop never rescues a write.
        rx_push    = wren_i & ~rx_full;
        rx_drop    = wren_i & rx_full;
        rx_pop     = (rx_wp_q != rx_rp_q) & rx_ready_i;
        rx_wp_d    = rx_push ? rx_wp_q + ONE : rx_wp_q;
        rx_rp_d    = rx_pop ? rx_rp_q + ONE : rx_rp_q;
        misrt      = (pckt_i[P-1 -: PCKT_XADDR_W] != PCKT_XADDR_W'(X_CORD))
                   | (pckt_i[PCKT_DATA_W +: PCKT_YADDR_W] != PCKT_YADDR_W'(Y_CORD));
        ovrflw_d   = rx_drop;
        rx_cnt_d   = rx_cnt_q + CNT_W'(rx_push);
        drop_cnt_d = drop_cnt_q + 8'(rx_drop & (drop_cnt_q != 8'hFF));
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= {tx_xaddr_i, tx_yaddr_i, tx_data_i};
        if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= {misrt, pckt_i[PCKT_DATA_W-1:0]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            wren_q     <= 1'b0;
            pckt_q     <= '0;
            ovrflw_q   <= 1'b0;
            tx_err_q   <= 1'b0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            wren_q     <= wren_d;
            pckt_q     <= pckt_d;
            ovrflw_q   <= ovrflw_d;
            tx_err_q   <= tx_err_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign tx_ready_o = ~tx_full;
    assign pckt_o     = pckt_q;
    assign wren_o     = wren_q;
    assign full_o     = rx_full;
    assign ovrflw_o   = ovrflw_q;
    assign rx_data_o  = rx_head[PCKT_DATA_W-1:0];
    assign rx_misrt_o = rx_head[PCKT_DATA_W];
    assign rx_valid_o = rx_wp_q != rx_rp_q;
    assign tx_err_o   = tx_err_q;
    assign tx_cnt_o   = tx_cnt_q;
    assign rx_cnt_o   = rx_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_noc_rsc_ni.sv
// tb_noc_rsc_ni: directed bench for the resource NI at node (1,1).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_noc_rsc_ni;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  tx_data_i = '0;
    logic [1:0]  tx_xaddr_i = '0, tx_yaddr_i = '0;
    logic        tx_valid_i = 1'b0, tx_ready_o;
    logic [11:0] pckt_o, pckt_i = '0;
    logic        wren_o, full_i = 1'b0, ovrflw_i = 1'b0, wren_i = 1'b0;
    logic        full_o, ovrflw_o, rx_misrt_o, rx_valid_o, rx_ready_i = 1'b0, tx_err_o;
    logic [7:0]  rx_data_o, drop_cnt_o;
    logic [15:0] tx_cnt_o, rx_cnt_o;
    int checks = 0;
    int failures = 0;

    noc_rsc_ni #(.X_CORD(1), .Y_CORD(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .tx_data_i(tx_data_i), .tx_xaddr_i(tx_xaddr_i), .tx_yaddr_i(tx_yaddr_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .pckt_o(pckt_o), .wren_o(wren_o), .full_i(full_i), .ovrflw_i(ovrflw_i),
        .pckt_i(pckt_i), .wren_i(wren_i), .full_o(full_o), .ovrflw_o(ovrflw_o),
        .rx_data_o(rx_data_o), .rx_misrt_o(rx_misrt_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .tx_err_o(tx_err_o),
        .tx_cnt_o(tx_cnt_o), .rx_cnt_o(rx_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++; if ({tx_ready_o, wren_o, full_o, ovrflw_o, rx_valid_o, tx_err_o} !== 6'b100000) begin failures++; $display("FAIL reset_flags got %b exp 100000", {tx_ready_o, wren_o, full_o, ovrflw_o, rx_valid_o, tx_err_o}); end
        checks++; if (pckt_o !== 12'h000) begin failures++; $display("FAIL reset_pckt got %h exp 000", pckt_o); end
        checks++; if ({tx_cnt_o, rx_cnt_o, drop_cnt_o} !== 40'h0) begin failures++; $display("FAIL reset_cnts got %h exp 0", {tx_cnt_o, rx_cnt_o, drop_cnt_o}); end
        tick;
        rst_ni = 1'b1;
        tick;
    endtask

    task automatic test_tx_single;
        tx_data_i = 8'hA5; tx_xaddr_i = 2'd1; tx_yaddr_i = 2'd2; tx_valid_i = 1'b1;
        tick;
        tx_valid_i = 1'b0;
        checks++; if (wren_o !== 1'b0) begin failures++; $display("FAIL tx1_early_wren got %b exp 0", wren_o); end
        tick;
        checks++; if (wren_o !== 1'b1) begin failures++; $display("FAIL tx1_wren got %b exp 1", wren_o); end
        checks++; if (pckt_o !== 12'h6A5) begin failures++; $display("FAIL tx1_pckt got %h exp 6a5", pckt_o); end
        tick;
        checks++; if (wren_o !== 1'b0) begin failures++; $display("FAIL tx1_wren_drop got %b exp 0", wren_o); end
        checks++; if (tx_cnt_o !== 16'd1) begin failures++; $display("FAIL tx1_cnt got %0d exp 1", tx_cnt_o); end
    endtask

    task automatic test_tx_backpressure;
        logic [11:0] exp_p [9];
        int seen = 0;
        full_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_xaddr_i = 2'(i); tx_yaddr_i = 2'(i >> 1); tx_data_i = 8'(8'h10 + i);
            exp_p[i] = {2'(i), 2'(i >> 1), 8'(8'h10 + i)};
            tx_valid_i = 1'b1;
            tick;
            seen += int'(wren_o);
        end
        checks++; if (tx_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_full got %b exp 0", tx_ready_o); end
        checks++; if (seen != 0) begin failures++; $display("FAIL bp_no_wren got %0d exp 0", seen); end
        tx_xaddr_i = 2'd3; tx_yaddr_i = 2'd3; tx_data_i = 8'h99; exp_p[8] = 12'hF99;
        tick;
        checks++; if ({tx_ready_o, wren_o} !== 2'b00) begin failures++; $display("FAIL bp_refused got %b exp 00", {tx_ready_o, wren_o}); end
        full_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick;
            if (k == 0) begin
                checks++; if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_free got %b exp 1", tx_ready_o); end
            end
            if (k == 1) tx_valid_i = 1'b0;
            checks++; if ({wren_o, pckt_o} !== {1'b1, exp_p[k]}) begin failures++; $display("FAIL bp_issue%0d got %b/%h exp 1/%h", k, wren_o, pckt_o, exp_p[k]); end
        end
        tick;
        checks++; if (wren_o !== 1'b0) begin failures++; $display("FAIL bp_idle got %b exp 0", wren_o); end
        checks++; if (tx_cnt_o !== 16'd10) begin failures++; $display("FAIL bp_cnt got %0d exp 10", tx_cnt_o); end
    endtask

    task automatic test_rx_route;
        pckt_i = {2'd1, 2'd1, 8'h3C}; wren_i = 1'b1;
        tick;
        pckt_i = {2'd0, 2'd1, 8'hC3};
        tick;
        pckt_i = {2'd1, 2'd0, 8'h5A};
        tick;
        wren_i = 1'b0;
        checks++; if ({rx_valid_o, rx_misrt_o, rx_data_o} !== {1'b1, 1'b0, 8'h3C}) begin failures++; $display("FAIL rt_head0 got %b/%b/%h exp 1/0/3c", rx_valid_o, rx_misrt_o, rx_data_o); end
        checks++; if (rx_cnt_o !== 16'd3) begin failures++; $display("FAIL rt_cnt got %0d exp 3", rx_cnt_o); end
        rx_ready_i = 1'b1;
        tick;
        rx_ready_i = 1'b0;
        checks++; if ({rx_valid_o, rx_misrt_o, rx_data_o} !== {1'b1, 1'b1, 8'hC3}) begin failures++; $display("FAIL rt_head1 got %b/%b/%h exp 1/1/c3", rx_valid_o, rx_misrt_o, rx_data_o); end
        tick;
        checks++; if ({rx_valid_o, rx_misrt_o, rx_data_o} !== {1'b1, 1'b1, 8'hC3}) begin failures++; $display("FAIL rt_hold got %b/%b/%h exp 1/1/c3", rx_valid_o, rx_misrt_o, rx_data_o); end
        rx_ready_i = 1'b1;
        tick;
        checks++; if ({rx_valid_o, rx_misrt_o, rx_data_o} !== {1'b1, 1'b1, 8'h5A}) begin failures++; $display("FAIL rt_head2 got %b/%b/%h exp 1/1/5a", rx_valid_o, rx_misrt_o, rx_data_o); end
        tick;
        rx_ready_i = 1'b0;
        checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL rt_empty got %b exp 0", rx_valid_o); end
    endtask

    task automatic test_rx_overflow;
        wren_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pckt_i = {2'd1, 2'd1, 8'(8'h40 + i)};
            tick;
        end
        checks++; if ({full_o, ovrflw_o} !== 2'b10) begin failures++; $display("FAIL ov_full got %b exp 10", {full_o, ovrflw_o}); end
        pckt_i = {2'd1, 2'd1, 8'hEE};
        tick;
        wren_i = 1'b0;
        checks++; if ({full_o, ovrflw_o} !== 2'b11) begin failures++; $display("FAIL ov_pulse got %b exp 11", {full_o, ovrflw_o}); end
        checks++; if (drop_cnt_o !== 8'd1) begin failures++; $display("FAIL ov_drop_cnt got %0d exp 1", drop_cnt_o); end
        checks++; if (rx_cnt_o !== 16'd11) begin failures++; $display("FAIL ov_rx_cnt got %0d exp 11", rx_cnt_o); end
        tick;
        checks++; if (ovrflw_o !== 1'b0) begin failures++; $display("FAIL ov_pulse_end got %b exp 0", ovrflw_o); end
    endtask

    task automatic test_rx_full_pop;
        pckt_i = {2'd1, 2'd1, 8'h77}; wren_i = 1'b1; rx_ready_i = 1'b1;
        tick;
        wren_i = 1'b0; rx_ready_i = 1'b0;
        checks++; if ({full_o, ovrflw_o, rx_data_o} !== {1'b0, 1'b1, 8'h41}) begin failures++; $display("FAIL fp_state got %b/%b/%h exp 0/1/41", full_o, ovrflw_o, rx_data_o); end
        checks++; if ({drop_cnt_o, rx_cnt_o} !== {8'd2, 16'd11}) begin failures++; $display("FAIL fp_cnts got %0d/%0d exp 2/11", drop_cnt_o, rx_cnt_o); end
        pckt_i = {2'd2, 2'd1, 8'h88}; wren_i = 1'b1;
        tick;
        wren_i = 1'b0;
        checks++; if (full_o !== 1'b1) begin failures++; $display("FAIL fp_refill got %b exp 1", full_o); end
        rx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [8:0] e;
            e = (i < 7) ? {1'b0, 8'(8'h41 + i)} : {1'b1, 8'h88};
            checks++; if ({rx_valid_o, rx_misrt_o, rx_data_o} !== {1'b1, e}) begin failures++; $display("FAIL fp_drain%0d got %b/%b/%h exp 1/%b/%h", i, rx_valid_o, rx_misrt_o, rx_data_o, e[8], e[7:0]); end
            tick;
        end
        rx_ready_i = 1'b0;
        checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL fp_empty got %b exp 0", rx_valid_o); end
    endtask

    task automatic test_err_and_reset;
        ovrflw_i = 1'b1;
        tick;
        ovrflw_i = 1'b0;
        checks++; if (tx_err_o !== 1'b1) begin failures++; $display("FAIL err_set got %b exp 1", tx_err_o); end
        tick; tick;
        checks++; if (tx_err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got %b exp 1", tx_err_o); end
        tx_data_i = 8'h33; tx_xaddr_i = 2'd2; tx_yaddr_i = 2'd2; tx_valid_i = 1'b1;
        pckt_i = {2'd1, 2'd1, 8'h66}; wren_i = 1'b1;
        tick; tick; tick;
        #3;
        rst_ni = 1'b0;
        #1;
        checks++; if ({tx_ready_o, wren_o, full_o, ovrflw_o, rx_valid_o, tx_err_o} !== 6'b100000) begin failures++; $display("FAIL rst_flags got %b exp 100000", {tx_ready_o, wren_o, full_o, ovrflw_o, rx_valid_o, tx_err_o}); end
        checks++; if (pckt_o !== 12'h000) begin failures++; $display("FAIL rst_pckt got %h exp 000", pckt_o); end
        checks++; if ({tx_cnt_o, rx_cnt_o, drop_cnt_o} !== 40'h0) begin failures++; $display("FAIL rst_cnts got %h exp 0", {tx_cnt_o, rx_cnt_o, drop_cnt_o}); end
        tx_valid_i = 1'b0; wren_i = 1'b0;
        tick;
        rst_ni = 1'b1;
        tick; tick; tick;
        checks++; if ({wren_o, rx_valid_o, tx_cnt_o} !== 18'h0) begin failures++; $display("FAIL rst_discard got %b/%b/%0d exp 0/0/0", wren_o, rx_valid_o, tx_cnt_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_tx_single;
        test_tx_backpressure;
        test_rx_route;
        test_rx_overflow;
        test_rx_full_pop;
        test_err_and_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
